// File: rtl/osc_cfg_pkg.sv
// Shared types and register map for the osc_bufg boot configuration sequencer.
// OSC_CFG_TS_LOAD_EN adds the timestamp-load states to the state enum.
package osc_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY_HI,
        ST_KEY_LO,
`ifdef OSC_CFG_TS_LOAD_EN
        ST_TS_HI,
        ST_TS_LO,
`endif
        ST_CFG_HI,
        ST_CFG_LO,
        ST_WAIT_ST
    } cfg_state_e;

    localparam logic [15:0] ADDR_CFG_DONE = 16'h0020;
    localparam logic [15:0] ADDR_TS_LOAD  = 16'h00D0;
    localparam logic [15:0] ADDR_ENCRYPT0 = 16'h0164;
    localparam logic [15:0] DATA_ONE      = 16'h0001;
    localparam int unsigned KEY_WORDS     = 4;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/osc_cfg_wr_phase.sv
// HI/LO phase timer shared by every write state: start begins a write,
// hi_done marks the last wr_en-high cycle, lo_done the last wr_en-low cycle.
module osc_cfg_wr_phase import osc_cfg_pkg::*; #(
    parameter int unsigned WR_HI_CYC = 4,
    parameter int unsigned WR_LO_CYC = 4
) (
    input  logic clk_osc_bufg,
    input  logic reset_osc_bufg,
    input  logic start,
    output logic hi_done,
    output logic lo_done
);

    localparam int unsigned TOT_CYC = WR_HI_CYC + WR_LO_CYC;
    localparam int unsigned CNT_W   = clog2_min1(TOT_CYC);

    logic [CNT_W-1:0] cnt;
    logic             running;

    always_ff @(posedge clk_osc_bufg) begin
        if (reset_osc_bufg) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (cnt == CNT_W'(TOT_CYC - 1))
                running <= 1'b0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    assign hi_done = running && (cnt == CNT_W'(WR_HI_CYC - 1));
    assign lo_done = running && (cnt == CNT_W'(TOT_CYC - 1));

endmodule

// File: rtl/osc_bufg_cfg_seq.sv
// Boot-time key/commit write sequencer and register-bus arbiter (SPI vs sequencer).
// Define OSC_CFG_TS_LOAD_EN to insert a timestamp-load write before the commit.
module osc_bufg_cfg_seq import osc_cfg_pkg::*; #(
    parameter int unsigned SPI_ADDR_LENGTH = 16,
    parameter int unsigned SHORT_REG_WD    = 16,
    parameter int unsigned LONG_REG_WD     = 64,
    parameter int unsigned WR_HI_CYC       = 4,
    parameter int unsigned WR_LO_CYC       = 4,
    parameter int unsigned TIMEOUT_CYC     = 4000000
) (
    input  logic                       clk_osc_bufg,
    input  logic                       reset_osc_bufg,
    input  logic                       i_start,
    input  logic [LONG_REG_WD-1:0]     iv_key,
    input  logic                       i_encrypt_state,
    input  logic                       i_spi_wr_en,
    input  logic                       i_spi_rd_en,
    input  logic [SPI_ADDR_LENGTH-1:0] iv_spi_addr,
    input  logic [SHORT_REG_WD-1:0]    iv_spi_wr_data,
    output logic                       o_wr_en,
    output logic                       o_rd_en,
    output logic [SPI_ADDR_LENGTH-1:0] ov_addr,
    output logic [SHORT_REG_WD-1:0]    ov_wr_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_fail,
    output logic [7:0]                 ov_spi_drop_cnt
);

    localparam int unsigned TMO_W = clog2_min1(TIMEOUT_CYC);

    cfg_state_e                 state;
    logic [LONG_REG_WD-1:0]     key_q;
    logic [1:0]                 word_idx;
    logic [1:0]                 next_idx;
    logic [TMO_W-1:0]           tmo_cnt;
    logic                       seq_wr_en;
    logic [SPI_ADDR_LENGTH-1:0] seq_addr;
    logic [SHORT_REG_WD-1:0]    seq_data;
    logic                       enc_s1, enc_s2;
    logic                       spi_s1, spi_s2, spi_s3;
    logic                       accept, phase_start, hi_done, lo_done, spi_rise;

    assign accept      = (state == ST_IDLE) && i_start;
    assign phase_start = accept || (lo_done && (state != ST_CFG_LO));
    assign next_idx    = word_idx + 2'd1;
    assign spi_rise    = spi_s2 && !spi_s3;

    osc_cfg_wr_phase #(
        .WR_HI_CYC (WR_HI_CYC),
        .WR_LO_CYC (WR_LO_CYC)
    ) u_wr_phase (
        .clk_osc_bufg   (clk_osc_bufg),
        .reset_osc_bufg (reset_osc_bufg),
        .start          (phase_start),
        .hi_done        (hi_done),
        .lo_done        (lo_done)
    );

    // key_q shifts left one word per write so the next word is always at the top.
    always_ff @(posedge clk_osc_bufg) begin
        if (reset_osc_bufg) begin
            state     <= ST_IDLE;
            key_q     <= '0;
            word_idx  <= '0;
            tmo_cnt   <= '0;
            seq_wr_en <= 1'b0;
            seq_addr  <= '0;
            seq_data  <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_fail    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        key_q     <= iv_key << SHORT_REG_WD;
                        word_idx  <= '0;
                        seq_wr_en <= 1'b1;
                        seq_addr  <= SPI_ADDR_LENGTH'(ADDR_ENCRYPT0);
                        seq_data  <= iv_key[LONG_REG_WD-1 -: SHORT_REG_WD];
                        o_busy    <= 1'b1;
                        o_done    <= 1'b0;
                        o_fail    <= 1'b0;
                        state     <= ST_KEY_HI;
                    end
                end
                ST_KEY_HI: begin
                    if (hi_done) begin
                        seq_wr_en <= 1'b0;
                        state     <= ST_KEY_LO;
                    end
                end
                ST_KEY_LO: begin
                    if (lo_done) begin
                        seq_wr_en <= 1'b1;
                        if (word_idx == 2'(KEY_WORDS - 1)) begin
`ifdef OSC_CFG_TS_LOAD_EN
                            seq_addr <= SPI_ADDR_LENGTH'(ADDR_TS_LOAD);
                            seq_data <= SHORT_REG_WD'(DATA_ONE);
                            state    <= ST_TS_HI;
`else
                            seq_addr <= SPI_ADDR_LENGTH'(ADDR_CFG_DONE);
                            seq_data <= SHORT_REG_WD'(DATA_ONE);
                            state    <= ST_CFG_HI;
`endif
                        end else begin
                            word_idx <= next_idx;
                            seq_addr <= SPI_ADDR_LENGTH'(ADDR_ENCRYPT0) + SPI_ADDR_LENGTH'(next_idx);
                            seq_data <= key_q[LONG_REG_WD-1 -: SHORT_REG_WD];
                            key_q    <= key_q << SHORT_REG_WD;
                            state    <= ST_KEY_HI;
                        end
                    end
                end
`ifdef OSC_CFG_TS_LOAD_EN
                ST_TS_HI: begin
                    if (hi_done) begin
                        seq_wr_en <= 1'b0;
                        state     <= ST_TS_LO;
                    end
                end
                ST_TS_LO: begin
                    if (lo_done) begin
                        seq_wr_en <= 1'b1;
                        seq_addr  <= SPI_ADDR_LENGTH'(ADDR_CFG_DONE);
                        seq_data  <= SHORT_REG_WD'(DATA_ONE);
                        state     <= ST_CFG_HI;
                    end
                end
`endif
                ST_CFG_HI: begin
                    if (hi_done) begin
                        seq_wr_en <= 1'b0;
                        state     <= ST_CFG_LO;
                    end
                end
                ST_CFG_LO: begin
                    if (lo_done) begin
                        tmo_cnt <= '0;
                        state   <= ST_WAIT_ST;
                    end
                end
                ST_WAIT_ST: begin
                    if (enc_s2) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        o_fail <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // An SPI write rising on the acceptance cycle already lost the bus, so it counts.
    always_ff @(posedge clk_osc_bufg) begin
        if (reset_osc_bufg) begin
            enc_s1          <= 1'b0;
            enc_s2          <= 1'b0;
            spi_s1          <= 1'b0;
            spi_s2          <= 1'b0;
            spi_s3          <= 1'b0;
            ov_spi_drop_cnt <= '0;
        end else begin
            enc_s1 <= i_encrypt_state;
            enc_s2 <= enc_s1;
            spi_s1 <= i_spi_wr_en;
            spi_s2 <= spi_s1;
            spi_s3 <= spi_s2;
            if (spi_rise && (o_busy || accept) && (ov_spi_drop_cnt != 8'hFF))
                ov_spi_drop_cnt <= ov_spi_drop_cnt + 8'd1;
        end
    end

    always_comb begin
        if (state == ST_IDLE) begin
            o_wr_en    = i_spi_wr_en;
            o_rd_en    = i_spi_rd_en;
            ov_addr    = iv_spi_addr;
            ov_wr_data = iv_spi_wr_data;
        end else begin
            o_wr_en    = seq_wr_en;
            o_rd_en    = 1'b0;
            ov_addr    = seq_addr;
            ov_wr_data = seq_data;
        end
    end

endmodule

// File: doc/osc_bufg_cfg_seq.md
# osc_bufg_cfg_seq

Boot-time configuration sequencer and bus arbiter for the 40 MHz osc_bufg register list. On a start pulse it takes ownership of the shared register write bus and writes the 64-bit encrypt key as four 16-bit words. It then pulses the parameter-commit register and waits for the DNA block to report the encryption state. Outside a sequence it passes the SPI-decoded bus through unchanged.

## Interface
Parameters:
- SPI_ADDR_LENGTH, 16, register address width
- SHORT_REG_WD, 16, register data width
- LONG_REG_WD, 64, key width (must equal 4×SHORT_REG_WD)
- WR_HI_CYC, 4, cycles wr_en is held high per write (≥3)
- WR_LO_CYC, 4, cycles wr_en is held low after each write (≥3)
- TIMEOUT_CYC, 4000000, cycles to wait for encrypt state (100 ms at 40 MHz)

Ports:
- clk_osc_bufg  in  1  40 MHz clock; sole clock of the block
- reset_osc_bufg  in  1  synchronous, active-high reset
- i_start  in  1  single-cycle request to run the sequence
- iv_key  in  LONG_REG_WD  key; sampled on the cycle i_start is accepted
- i_encrypt_state  in  1  clk_dna domain; synchronized internally
- i_spi_wr_en / i_spi_rd_en  in  1  SPI-side strobes (asynchronous)
- iv_spi_addr  in  SPI_ADDR_LENGTH  SPI-side address
- iv_spi_wr_data  in  SHORT_REG_WD  SPI-side write data
- o_wr_en / o_rd_en  out  1  to register list
- ov_addr  out  SPI_ADDR_LENGTH  to register list
- ov_wr_data  out  SHORT_REG_WD  to register list
- o_busy  out  1  sequencer owns the bus
- o_done  out  1  sticky: last sequence passed
- o_fail  out  1  sticky: last sequence timed out
- ov_spi_drop_cnt  out  8  saturating count of SPI writes dropped while busy

## Operation
- States: IDLE → KEY_HI → KEY_LO (×4 words, index 0..3) → [TS_HI → TS_LO] → CFG_HI → CFG_LO → WAIT_ST → IDLE.
- IDLE: the bus muxes to the SPI inputs combinationally, and o_busy=0. i_start is accepted only in IDLE and ignored otherwise. On acceptance: latch iv_key, clear o_done and o_fail, set o_busy.
- KEY word n: address 0x164+n, data = key[LONG_REG_WD-1-16n -: 16], MSW first.
- CFG: address 0x020, data 0x0001.
- Each *_HI state drives o_wr_en=1 for WR_HI_CYC cycles. Each *_LO state drives o_wr_en=0 for WR_LO_CYC cycles. Address and data stay stable through both phases.
- When busy: o_rd_en=0, and the SPI inputs are ignored.
- WAIT_ST:
  - Synchronized i_encrypt_state=1 → o_done=1, go to IDLE.
  - TIMEOUT_CYC cycles elapse first → o_fail=1, go to IDLE.
- SPI drop count: i_spi_wr_en is passed through a 2-FF synchronizer. Each rising edge seen while o_busy=1 increments ov_spi_drop_cnt, saturating at 255. The count clears only on reset.

## Timing
- Reset values: o_wr_en=0, o_rd_en=0, ov_addr=0, ov_wr_data=0, o_busy=0, o_done=0, o_fail=0, ov_spi_drop_cnt=0. State returns to IDLE.
- A reset asserted mid-sequence aborts it immediately. The next cycle already muxes the bus to SPI.
- o_busy rises on the cycle after i_start is sampled. The first o_wr_en=1 appears on that same cycle.
- Bus outputs in sequencer mode are registered.
- Write phase timing:
  - Each write takes WR_HI_CYC+WR_LO_CYC cycles.
  - Defaults: 4 keys + 1 commit = 40 cycles before WAIT_ST.
- Timeout counter:
  - Starts at 0 on entry to WAIT_ST and is compared against TIMEOUT_CYC-1.
  - Width is $clog2(TIMEOUT_CYC).
- i_start arriving on the same cycle the state returns to IDLE is ignored. A new start is accepted from the following cycle.
- SPI write collision: an SPI write whose rising edge coincides with the i_start acceptance cycle is counted as dropped.

## Configuration
- OSC_CFG_TS_LOAD_EN:
  - Defined: one extra write (address 0x0D0, data 0x0001) is inserted between the last key word and CFG, loading the timestamp on the same boot. Default sequence becomes 48 cycles before WAIT_ST.
  - Undefined: the TS states are not compiled, and the sequence goes directly from the key words to CFG.

## Structure
- Shared package osc_cfg_pkg:
  - state enum
  - address constants ADDR_CFG_DONE=0x020, ADDR_TS_LOAD=0x0D0, ADDR_ENCRYPT0=0x164
- One sub-module, osc_cfg_wr_phase: the HI/LO cycle counter with start/done handshake, reused by every write state.
- The 2-FF synchronizers are instantiated inline.

## Test plan
- Reset, then i_start with iv_key=0x1122_3344_5566_7788 → writes 0x1122@0x164, 0x3344@0x165, 0x5566@0x166, 0x7788@0x167, then 0x0001@0x020. Each write has wr_en high 4 cycles and low 4 cycles.
- After CFG, i_encrypt_state rises 100 cycles later → o_done=1 within 3 cycles, o_busy=0, and the bus returns to SPI pass-through.
- i_encrypt_state held 0, TIMEOUT_CYC=1000 → o_fail=1 exactly 1000 cycles after WAIT_ST entry, and o_done stays 0.
- Three SPI write pulses during a sequence → none reach o_wr_en and ov_spi_drop_cnt=3. 300 pulses → the count saturates at 255.
- Reset asserted during key word 2 → all outputs return to reset values the next cycle, and a fresh i_start restarts from word 0.
- With OSC_CFG_TS_LOAD_EN defined → a 0x0001@0x0D0 write appears between 0x167 and 0x020. Without it → no access to 0x0D0.
